// File: rtl/sfu_pkg.sv
// sfu_pkg: FSM state encoding and SFU op-select encodings shared with the SFU controller
package sfu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam int SFU_OP_W = 3;
  localparam logic [SFU_OP_W-1:0] OP_RCP = 3'd0;
  localparam logic [SFU_OP_W-1:0] OP_RSQ = 3'd1;
  localparam logic [SFU_OP_W-1:0] OP_EX2 = 3'd2;
  localparam logic [SFU_OP_W-1:0] OP_LG2 = 3'd3;
  localparam logic [SFU_OP_W-1:0] OP_SIN = 3'd4;
  localparam logic [SFU_OP_W-1:0] OP_COS = 3'd5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : encoded grant index
//   any : at least one request pending
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  assign any = |req;
  // Scan from the farthest offset down so the nearest request to ptr is written last and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = ID_W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/sfu_scheduler.sv
// sfu_scheduler: round-robin sharing of one SFU between NUM_REQ requesters
//   req_*  : per-requester valid/ready with packed operand and op-select slices
//   sfu_*  : issue handshake to the SFU, single-cycle done pulse with result
//   rsp_*  : response to the originating requester, err flags a WAIT timeout
//   busy_o : an operation is in flight
module sfu_scheduler
  import sfu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = SFU_OP_W,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_selop_i,
  output logic                      sfu_valid_o,
  input  logic                      sfu_ready_i,
  output logic [DATA_W-1:0]         sfu_data_o,
  output logic [OP_W-1:0]           sfu_selop_o,
  input  logic                      sfu_done_i,
  input  logic [DATA_W-1:0]         sfu_result_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      busy_o
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic              any;
  logic [CNT_W-1:0]  cnt;
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid_i),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(any)
  );
  // Gated by reset as well so no requester sees an accept while the block is held in reset.
  assign req_ready_o = (state == IDLE && rst) ? gnt : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      sfu_valid_o <= 1'b0;
      sfu_data_o  <= '0;
      sfu_selop_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state       <= ISSUE;
          sfu_valid_o <= 1'b1;
          busy_o      <= 1'b1;
          sfu_data_o  <= req_data_i[gnt_idx*DATA_W +: DATA_W];
          sfu_selop_o <= req_selop_i[gnt_idx*OP_W +: OP_W];
          rsp_id_o    <= gnt_idx;
        end
        ISSUE: if (sfu_ready_i) begin
          state       <= WAIT;
          sfu_valid_o <= 1'b0;
          cnt         <= '0;
        end
        // A done pulse on the last counted cycle still returns the real result.
        WAIT: if (sfu_done_i || cnt == CNT_W'(TIMEOUT - 1)) begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= sfu_done_i ? sfu_result_i : '0;
          rsp_err_o   <= !sfu_done_i;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RESP: if (rsp_ready_i) begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          rr_ptr      <= (rsp_id_o == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_o + ID_W'(1);
        end
      endcase
    end
  end
endmodule

// File: doc/sfu_scheduler.md
Name: sfu_scheduler

Overview:
Round-robin scheduler sharing one SFU between NUM_REQ requesters (lanes/cores). It accepts one operation at a time and issues it to the SFU issue stage. It waits for SFU completion, with a timeout, and returns the result to the originating requester. It sits between the requester ports and the SFU controller/datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 3, SFU operation select width
TIMEOUT, 64, max cycles in WAIT before error response (>=2)
ID_W, 2, requester index width, must be >= clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data_i  in  NUM_REQ*DATA_W  packed operands, requester k at [k*DATA_W +: DATA_W]
req_selop_i  in  NUM_REQ*OP_W  packed op selects, same packing
sfu_valid_o  out  1  issue valid to SFU
sfu_ready_i  in  1  SFU can accept issue
sfu_data_o  out  DATA_W  operand to SFU
sfu_selop_o  out  OP_W  op select to SFU
sfu_done_i  in  1  SFU result valid (single-cycle pulse)
sfu_result_i  in  DATA_W  SFU result
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumer ready
rsp_id_o  out  ID_W  requester index of response
rsp_data_o  out  DATA_W  result (0 on error)
rsp_err_o  out  1  timeout flag
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; rr_ptr=0; all registered outputs 0. req_ready_o=0, sfu_valid_o=0, rsp_valid_o=0, rsp_err_o=0, sfu_data_o=0, sfu_selop_o=0, rsp_data_o=0, rsp_id_o=0. Reset mid-operation drops the in-flight op with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first k with req_valid_i[k]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready_o[grant]=1 combinationally in the same cycle; all other bits 0.
  - At the clock edge, latch req_data_i/req_selop_i slices of grant into the sfu_* registers, latch grant into the id register, and go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - sfu_valid_o=1; sfu_data_o/sfu_selop_o held stable.
  - sfu_ready_i=1: go to WAIT next cycle and clear the timeout counter.
  - sfu_ready_i=0: hold indefinitely (no timeout in ISSUE).
- WAIT:
  - sfu_valid_o=0; the counter increments each cycle.
  - sfu_done_i=1: latch sfu_result_i into rsp_data_o, set rsp_err_o=0, go to RESP.
  - Else, counter == TIMEOUT-1: rsp_data_o=0, rsp_err_o=1, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid_o=1; rsp_id_o/rsp_data_o/rsp_err_o held stable.
  - rsp_ready_i=1: rr_ptr = id+1 (wrap to 0 at NUM_REQ), go to IDLE.
- sfu_done_i in any state other than WAIT is ignored (late result after timeout discarded).
- Latency, no stalls: accept at cycle 0, sfu_valid_o high at cycle 1, done at cycle 1+L+1, rsp_valid_o the following cycle. Minimum accept-to-accept time is 4 cycles + SFU latency.
- Fairness: with all requesters continuously valid from reset, grant order is 0,1,2,3,0,...
- req_ready_o is never asserted outside IDLE. A requester drops req_valid_i only after its handshake.

Decomposition:
- Package sfu_pkg: state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and SFU op-select width/encodings shared with the SFU controller.
- One sub-module, rr_arbiter: combinational rotating-priority picker. Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded index.

Test Plan:
1. Single request, no stalls: req_valid_i=4'b0100, data=0x3F800000, selop=3'd2; SFU ready, done after 5 cycles with 0x40000000. Required: req_ready_o=4'b0100 for 1 cycle; sfu_valid_o 1 cycle, sfu_selop_o=2; rsp_id_o=2, rsp_data_o=0x40000000, rsp_err_o=0.
2. All four valid from reset, rsp_ready_i=1: grants 0,1,2,3,0 in order; each rsp_id_o matches its grant.
3. Wrap-around: rr_ptr=3 after serving id 2, with req_valid_i=4'b1001. Required: id 3 served first, then id 0.
4. Timeout: sfu_done_i never asserted in WAIT. Required: exactly TIMEOUT cycles later, rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0. A late sfu_done_i in RESP or IDLE is ignored.
5. Backpressure: sfu_ready_i=0 for 10 cycles then 1; rsp_ready_i=0 for 5 cycles. Required: sfu and rsp outputs stable throughout; no new req_ready_o until RESP completes.
6. Reset mid-WAIT: assert rst=0 asynchronously. Required: outputs immediately 0, busy_o=0; after release, the first grant comes from rr_ptr=0.
